rv32v_fetch2_decode_queue: RTL and testbench

- Parametrised, buffered successor to the vector fetch2→decode hand-off.
- Replaces the flat wire bundle of instr, mal_insn and fault_insn with a DEPTH-entry FIFO carrying instruction, PC and fault flags.
- Uses valid/ready handshakes on both sides, a pipeline flush, and a fault fence that stops fetch behind a faulting instruction.
- Sits between the vector fetch2 stage and the vector decode stage; decouples fetch stalls from decode stalls.

---
 rtl/rv32v_fetch2_decode_queue.sv | 124 ++++++++++++
 tb/tb_rv32v_fetch2_decode_queue.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/rv32v_fetch2_decode_queue.sv
// Buffered fetch2 -> decode hand-off: DEPTH-entry FIFO of {instr, pc, mal, fault}
// with valid/ready on both sides, synchronous flush and an optional fault fence.
module rv32v_fetch2_decode_queue #(
    parameter int INSTR_WIDTH = 32,
    parameter int PC_WIDTH    = 32,
    parameter int DEPTH       = 4,
    parameter int FAULT_FENCE = 1
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         flush,
    input  logic                         enq_valid,
    output logic                         enq_ready,
    input  logic [INSTR_WIDTH-1:0]       enq_instr,
    input  logic [PC_WIDTH-1:0]          enq_pc,
    input  logic                         enq_mal_insn,
    input  logic                         enq_fault_insn,
    output logic                         deq_valid,
    input  logic                         deq_ready,
    output logic [INSTR_WIDTH-1:0]       deq_instr,
    output logic [PC_WIDTH-1:0]          deq_pc,
    output logic                         deq_mal_insn,
    output logic                         deq_fault_insn,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         fenced
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_FENCED = 1'b1;

    logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];
    logic [PC_WIDTH-1:0]    pc_mem    [DEPTH];
    logic [DEPTH-1:0]       mal_mem;
    logic [DEPTH-1:0]       fault_mem;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [0:0]    state_q, state_d;

    logic accept;
    logic pop;

    // A full queue refuses even when a pop is happening this cycle (no bypass).
    assign enq_ready = (count_q < FULL) && (state_q == ST_RUN) && !flush;
    assign deq_valid = (count_q != '0) && !flush;
    assign accept    = enq_valid && enq_ready;
    assign pop       = deq_valid && deq_ready;

    assign count  = count_q;
    assign fenced = (state_q == ST_FENCED);

    always_comb begin
        deq_instr      = '0;
        deq_pc         = '0;
        deq_mal_insn   = 1'b0;
        deq_fault_insn = 1'b0;
        if (deq_valid) begin
            deq_instr      = instr_mem[rd_ptr_q];
            deq_pc         = pc_mem[rd_ptr_q];
            deq_mal_insn   = mal_mem[rd_ptr_q];
            deq_fault_insn = fault_mem[rd_ptr_q];
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        state_d  = state_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            state_d  = ST_RUN;
        end else begin
            if (accept) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (accept && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !accept) begin
                count_d = count_q - CW'(1);
            end
            // Stop fetching behind a faulting instruction until the pipeline flushes.
            if (accept && (enq_mal_insn || enq_fault_insn) && (FAULT_FENCE != 0)) begin
                state_d = ST_FENCED;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= ST_RUN;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (accept) begin
            instr_mem[wr_ptr_q] <= enq_instr;
            pc_mem[wr_ptr_q]    <= enq_pc;
            mal_mem[wr_ptr_q]   <= enq_mal_insn;
            fault_mem[wr_ptr_q] <= enq_fault_insn;
        end
    end

    a_no_underflow: assert property (@(posedge CLK) disable iff (RST) !(pop && (count_q == '0)));
    a_no_overflow:  assert property (@(posedge CLK) disable iff (RST) !(accept && (count_q == FULL)));

endmodule

// File: tb/tb_rv32v_fetch2_decode_queue.sv
// Cycle-by-cycle vector bench for the fetch2 -> decode queue (DEPTH=4, fence on),
// followed by a hand-written asynchronous-reset sequence.
module tb_rv32v_fetch2_decode_queue;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        flush = 1'b0;
    logic        enq_valid = 1'b0;
    logic        enq_ready;
    logic [31:0] enq_instr = '0;
    logic [31:0] enq_pc = '0;
    logic        enq_mal_insn = 1'b0;
    logic        enq_fault_insn = 1'b0;
    logic        deq_valid;
    logic        deq_ready = 1'b0;
    logic [31:0] deq_instr;
    logic [31:0] deq_pc;
    logic        deq_mal_insn;
    logic        deq_fault_insn;
    logic [2:0]  count;
    logic        fenced;

    rv32v_fetch2_decode_queue #(
        .INSTR_WIDTH(32), .PC_WIDTH(32), .DEPTH(4), .FAULT_FENCE(1)
    ) dut (
        .CLK(CLK), .RST(RST), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_instr(enq_instr),
        .enq_pc(enq_pc), .enq_mal_insn(enq_mal_insn), .enq_fault_insn(enq_fault_insn),
        .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_instr(deq_instr),
        .deq_pc(deq_pc), .deq_mal_insn(deq_mal_insn), .deq_fault_insn(deq_fault_insn),
        .count(count), .fenced(fenced)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        flush;
        logic        ev;
        logic [31:0] pc;
        logic        mal;
        logic        fault;
        logic        dr;
        logic        e_ready;
        logic        e_dv;
        logic [31:0] e_pc;
        logic        e_mal;
        logic        e_fault;
        logic [2:0]  e_count;
        logic        e_fenced;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;
    int   cur = 0;

    // Instruction word is tied to the PC so 0x100 carries 0x00000013.
    function automatic logic [31:0] mk_instr(input logic [31:0] pc);
        return pc ^ 32'h0000_0113;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (step %0d): got %h expected %h", name, cur, act, exp);
        end
    endtask

    task automatic add(input logic fl, input logic ev, input logic [31:0] pc, input logic mal,
                       input logic fault, input logic dr, input logic e_ready, input logic e_dv,
                       input logic [31:0] e_pc, input logic e_mal, input logic e_fault,
                       input logic [2:0] e_count, input logic e_fenced);
        vec_t v;
        v.flush = fl; v.ev = ev; v.pc = pc; v.mal = mal; v.fault = fault; v.dr = dr;
        v.e_ready = e_ready; v.e_dv = e_dv; v.e_pc = e_pc; v.e_mal = e_mal;
        v.e_fault = e_fault; v.e_count = e_count; v.e_fenced = e_fenced;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic fl, input logic ev, input logic [31:0] pc, input logic mal,
                         input logic fault, input logic dr);
        flush = fl; enq_valid = ev; enq_pc = pc; enq_instr = mk_instr(pc);
        enq_mal_insn = mal; enq_fault_insn = fault; deq_ready = dr;
    endtask

    initial begin
        //  fl ev pc          mal flt dr | rdy dv  pc          mal flt cnt fen
        // Basic flow
        add(0, 1, 32'h100, 0, 0, 1,   1, 0, 32'h0,   0, 0, 3'd0, 0);
        add(0, 0, 32'h0,   0, 0, 1,   1, 1, 32'h100, 0, 0, 3'd1, 0);
        add(0, 0, 32'h0,   0, 0, 0,   1, 0, 32'h0,   0, 0, 3'd0, 0);
        // Fill and backpressure, fifth entry waits for space
        add(0, 1, 32'h200, 0, 0, 0,   1, 0, 32'h0,   0, 0, 3'd0, 0);
        add(0, 1, 32'h204, 0, 0, 0,   1, 1, 32'h200, 0, 0, 3'd1, 0);
        add(0, 1, 32'h208, 0, 0, 0,   1, 1, 32'h200, 0, 0, 3'd2, 0);
        add(0, 1, 32'h20c, 0, 0, 0,   1, 1, 32'h200, 0, 0, 3'd3, 0);
        add(0, 1, 32'h210, 0, 0, 0,   0, 1, 32'h200, 0, 0, 3'd4, 0);
        add(0, 1, 32'h210, 0, 0, 1,   0, 1, 32'h200, 0, 0, 3'd4, 0);
        add(0, 1, 32'h210, 0, 0, 1,   1, 1, 32'h204, 0, 0, 3'd3, 0);
        add(0, 0, 32'h0,   0, 0, 1,   1, 1, 32'h208, 0, 0, 3'd3, 0);
        add(0, 0, 32'h0,   0, 0, 1,   1, 1, 32'h20c, 0, 0, 3'd2, 0);
        add(0, 0, 32'h0,   0, 0, 1,   1, 1, 32'h210, 0, 0, 3'd1, 0);
        // Steady count=2 with concurrent enqueue/pop across pointer wrap
        add(0, 1, 32'h300, 0, 0, 0,   1, 0, 32'h0,   0, 0, 3'd0, 0);
        add(0, 1, 32'h304, 0, 0, 0,   1, 1, 32'h300, 0, 0, 3'd1, 0);
        for (int k = 0; k < 10; k++)
            add(0, 1, 32'h308 + 32'(4 * k), 0, 0, 1, 1, 1, 32'h300 + 32'(4 * k), 0, 0, 3'd2, 0);
        add(0, 0, 32'h0,   0, 0, 1,   1, 1, 32'h328, 0, 0, 3'd2, 0);
        add(0, 0, 32'h0,   0, 0, 1,   1, 1, 32'h32c, 0, 0, 3'd1, 0);
        // Fault fence: A, B(fault), C refused until flush
        add(0, 1, 32'h400, 0, 0, 0,   1, 0, 32'h0,   0, 0, 3'd0, 0);
        add(0, 1, 32'h404, 0, 1, 0,   1, 1, 32'h400, 0, 0, 3'd1, 0);
        add(0, 1, 32'h408, 0, 0, 0,   0, 1, 32'h400, 0, 0, 3'd2, 1);
        add(0, 1, 32'h408, 0, 0, 1,   0, 1, 32'h400, 0, 0, 3'd2, 1);
        add(0, 1, 32'h408, 0, 0, 1,   0, 1, 32'h404, 0, 1, 3'd1, 1);
        add(0, 1, 32'h408, 0, 0, 0,   0, 0, 32'h0,   0, 0, 3'd0, 1);
        add(1, 1, 32'h408, 0, 0, 0,   0, 0, 32'h0,   0, 0, 3'd0, 1);
        add(0, 1, 32'h408, 0, 0, 0,   1, 0, 32'h0,   0, 0, 3'd0, 0);
        add(0, 0, 32'h0,   0, 0, 1,   1, 1, 32'h408, 0, 0, 3'd1, 0);
        // Misaligned flag also fences
        add(0, 1, 32'h500, 1, 0, 0,   1, 0, 32'h0,   0, 0, 3'd0, 0);
        add(0, 0, 32'h0,   0, 0, 1,   0, 1, 32'h500, 1, 0, 3'd1, 1);
        add(1, 0, 32'h0,   0, 0, 0,   0, 0, 32'h0,   0, 0, 3'd0, 1);
        // Flush with data and an offered entry
        add(0, 1, 32'h600, 0, 0, 0,   1, 0, 32'h0,   0, 0, 3'd0, 0);
        add(0, 1, 32'h604, 0, 0, 0,   1, 1, 32'h600, 0, 0, 3'd1, 0);
        add(0, 1, 32'h608, 0, 0, 0,   1, 1, 32'h600, 0, 0, 3'd2, 0);
        add(1, 1, 32'h60c, 0, 0, 1,   0, 0, 32'h0,   0, 0, 3'd3, 0);
        add(0, 0, 32'h0,   0, 0, 1,   1, 0, 32'h0,   0, 0, 3'd0, 0);
        add(0, 1, 32'h700, 0, 0, 0,   1, 0, 32'h0,   0, 0, 3'd0, 0);
        add(0, 0, 32'h0,   0, 0, 1,   1, 1, 32'h700, 0, 0, 3'd1, 0);
        add(0, 0, 32'h0,   0, 0, 0,   1, 0, 32'h0,   0, 0, 3'd0, 0);

        // Reset state, checked while RST is held
        repeat (2) @(negedge CLK);
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_deq_valid", 32'(deq_valid), 32'd0);
        check("rst_fenced", 32'(fenced), 32'd0);
        check("rst_deq_instr", deq_instr, 32'd0);
        check("rst_enq_ready", 32'(enq_ready), 32'd1);
        RST = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            cur = i;
            @(negedge CLK);
            drive(vecs[i].flush, vecs[i].ev, vecs[i].pc, vecs[i].mal, vecs[i].fault, vecs[i].dr);
            #1;
            $display("step %0d: flush=%0b enq_valid=%0b pc=%h deq_ready=%0b -> enq_ready=%0b deq_valid=%0b deq_pc=%h count=%0d fenced=%0b",
                     i, flush, enq_valid, enq_pc, deq_ready, enq_ready, deq_valid, deq_pc, count, fenced);
            check("enq_ready", 32'(enq_ready), 32'(vecs[i].e_ready));
            check("deq_valid", 32'(deq_valid), 32'(vecs[i].e_dv));
            check("deq_pc", deq_pc, vecs[i].e_pc);
            check("deq_instr", deq_instr, vecs[i].e_dv ? mk_instr(vecs[i].e_pc) : 32'h0);
            check("deq_mal", 32'(deq_mal_insn), 32'(vecs[i].e_mal));
            check("deq_fault", 32'(deq_fault_insn), 32'(vecs[i].e_fault));
            check("count", 32'(count), 32'(vecs[i].e_count));
            check("fenced", 32'(fenced), 32'(vecs[i].e_fenced));
        end

        // Asynchronous reset between edges with three entries queued and the fence up
        cur = 1000;
        @(negedge CLK); drive(0, 1, 32'h800, 0, 0, 0);
        @(negedge CLK); drive(0, 1, 32'h804, 0, 0, 0);
        @(negedge CLK); drive(0, 1, 32'h808, 0, 1, 0);
        @(negedge CLK); drive(0, 0, 32'h0, 0, 0, 0);
        #1;
        $display("pre-reset: count=%0d fenced=%0b deq_pc=%h", count, fenced, deq_pc);
        check("pre_rst_count", 32'(count), 32'd3);
        check("pre_rst_fenced", 32'(fenced), 32'd1);
        check("pre_rst_deq_pc", deq_pc, 32'h800);
        #1;
        RST = 1'b1;
        #1;
        $display("async reset: count=%0d deq_valid=%0b fenced=%0b", count, deq_valid, fenced);
        check("arst_count", 32'(count), 32'd0);
        check("arst_deq_valid", 32'(deq_valid), 32'd0);
        check("arst_fenced", 32'(fenced), 32'd0);
        check("arst_deq_pc", deq_pc, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        cur = 1001;
        drive(0, 1, 32'h900, 0, 0, 0);
        #1;
        check("post_rst_enq_ready", 32'(enq_ready), 32'd1);
        @(negedge CLK);
        drive(0, 0, 32'h0, 0, 0, 1);
        #1;
        $display("post-reset: deq_valid=%0b deq_pc=%h count=%0d", deq_valid, deq_pc, count);
        check("post_rst_deq_pc", deq_pc, 32'h900);
        check("post_rst_count", 32'(count), 32'd1);
        @(negedge CLK);
        drive(0, 0, 32'h0, 0, 0, 0);
        #1;
        check("post_rst_empty", 32'(count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
